simon_sequence_player: RTL
==========================

// Module: simon_sequence_player
// PURPOSE
//   Source end of the Simon colour check. Grows a random 2-bit colour sequence,
//   plays it back on the LED outputs, then presents the expected colour per step
//   to the colour comparator and consumes its result (01 = match, 10 = mismatch).
//   Sits between the game top level (start button, LEDs) and the comparator.
// PARAMETERS
//   MAX_LEN     16       sequence length that wins the game (2..64)
//   ON_CYCLES   25000000 clocks an LED stays lit per playback step (>=1)
//   OFF_CYCLES  12500000 clocks of dark gap after each lit step (>=1)
//   SEED        16'hACE1 LFSR reset value; 0 is replaced by 16'hACE1
// PORTS
//   clk           in   1  system clock, all state on posedge
//   reset         in   1  asynchronous, active-high; forces IDLE
//   start         in   1  one-cycle pulse: begin a new game
//   result_valid  in   1  comparator result is valid this cycle
//   result        in   2  comparator output: 01 match, 10 mismatch
//   expected      out  2  colour the player must enter now (to comparator compare)
//   cmp_enable    out  1  comparator enable; high only in WAIT_INPUT
//   led_on        out  1  a playback LED is lit
//   led_colour    out  2  colour lit while led_on; 0 otherwise
//   level         out  7  current sequence length (0..MAX_LEN)
//   busy          out  1  high in every state except IDLE, WIN, LOSE
//   win           out  1  held high in WIN
//   game_over     out  1  held high in LOSE
// BEHAVIOUR
// - Reset: state IDLE, level=0, step index=0, timer=0, LFSR=SEED, all outputs 0.
//   Reset asserted mid-game aborts immediately; sequence memory is not cleared.
// - LFSR: 16-bit Galois, taps 16,14,13,11, advances every clock in all states.
// - All outputs are registered decodes of the state; visible the cycle the state is entered.
// - FSM:
//   IDLE/WIN/LOSE: start -> EXTEND with level=0; other inputs ignored.
//   EXTEND (1 cycle): mem[level]<=lfsr[1:0]; level++; idx=0 -> PLAY_ON.
//   PLAY_ON: led_on=1, led_colour=mem[idx]; after on-time clocks -> PLAY_OFF.
//   PLAY_OFF: dark for OFF_CYCLES; then idx++; idx==level ? (idx=0, WAIT_INPUT) : PLAY_ON.
//   WAIT_INPUT: expected=mem[idx], cmp_enable=1. On result_valid:
//     01 and idx<level-1 -> idx++, stay; 01 and idx==level-1 -> level==MAX_LEN ? WIN : EXTEND;
//     10 -> LOSE; 00/11 ignored. No timeout.
//   start ignored while busy; result_valid ignored outside WAIT_INPUT.
// - Latency: start at cycle n -> EXTEND n+1 -> led_on high from n+2.
// - Timer: 1 counter, width clog2(max(ON_CYCLES,OFF_CYCLES)+1), reloaded on each
//   state entry; a phase lasts exactly its cycle count (ON/OFF=1 -> 1 cycle).
// - expected holds mem[idx] in WAIT_INPUT, 0 elsewhere; level saturates at MAX_LEN.
// CONFIGURATION
//   SIMON_SPEEDUP_EN defined: on-time = ON_CYCLES >> min(level/4, 2) (floor 1),
//     i.e. playback speeds up at levels 4 and 8. OFF_CYCLES unchanged.
//   Not defined: on-time is ON_CYCLES at every level.
// TESTING (bench params ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4, SEED=16'h0001)
//   1. Reset release, start at n -> level=1 at n+1, led_on high n+2..n+5,
//      dark n+6..n+7, cmp_enable high at n+8, expected=mem[0].
//   2. Feed result=01 at each WAIT_INPUT step for 4 rounds -> win=1, level=4,
//      busy=0; start -> level=1, win=0.
//   3. Level 3, result=10 on second step -> game_over=1, cmp_enable=0,
//      later result_valid/start-free cycles change nothing.
//   4. result_valid with result=00 and 11 in WAIT_INPUT -> idx, state unchanged;
//      result_valid during PLAY_ON -> ignored.
//   5. reset pulsed mid PLAY_ON -> same-cycle async: all outputs 0, IDLE, level=0.
//   6. SIMON_SPEEDUP_EN, ON_CYCLES=8: level 1..3 lit 8 clocks, level 4 lit 4 clocks.

Source files
------------

// File: rtl/simon_sequence_player.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// simon_sequence_player
//   Source end of the Simon colour check. Each round appends one pseudo-random
//   2-bit colour to the sequence and plays the whole sequence back on the LED
//   outputs. It then presents the expected colour for each step to the colour
//   comparator and consumes the comparator's verdict.
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   asynchronous active-high reset, forces IDLE
//   start        in   one-cycle pulse, begins a new game from IDLE/WIN/LOSE
//   result_valid in   comparator verdict valid this cycle
//   result       in   comparator verdict: 01 match, 10 mismatch, others ignored
//   expected     out  colour the player must enter now (WAIT_INPUT only)
//   cmp_enable   out  comparator enable, high only in WAIT_INPUT
//   led_on       out  a playback LED is lit
//   led_colour   out  colour lit while led_on, 0 otherwise
//   level        out  current sequence length (0..MAX_LEN)
//   busy         out  high in every state except IDLE, WIN, LOSE
//   win          out  held high in WIN
//   game_over    out  held high in LOSE
//
// Configuration macro
//   SIMON_SPEEDUP_EN : when defined, the lit time per playback step is
//                      ON_CYCLES >> min(level/4, 2) (at least 1 clock).
//                      When undefined, every level uses ON_CYCLES.
// -----------------------------------------------------------------------------
module simon_sequence_player #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          OFF_CYCLES = 12500000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       result_valid,
    input  logic [1:0] result,
    output logic [1:0] expected,
    output logic       cmp_enable,
    output logic       led_on,
    output logic [1:0] led_colour,
    output logic [6:0] level,
    output logic       busy,
    output logic       win,
    output logic       game_over
);

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // The timer is loaded with (duration - 1) and the phase ends when it reads 0.
    localparam logic [TW-1:0] ON_LOAD_BASE = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD     = TW'(OFF_CYCLES - 1);
    localparam logic [6:0]    MAX_LEVEL    = 7'(MAX_LEN);

`ifdef SIMON_SPEEDUP_EN
    localparam int            ON_L4        = ((ON_CYCLES >> 1) > 0) ? (ON_CYCLES >> 1) : 1;
    localparam int            ON_L8        = ((ON_CYCLES >> 2) > 0) ? (ON_CYCLES >> 2) : 1;
    localparam logic [TW-1:0] ON_LOAD_L4   = TW'(ON_L4 - 1);
    localparam logic [TW-1:0] ON_LOAD_L8   = TW'(ON_L8 - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EXTEND     = 3'd1,
        ST_PLAY_ON    = 3'd2,
        ST_PLAY_OFF   = 3'd3,
        ST_WAIT_INPUT = 3'd4,
        ST_WIN        = 3'd5,
        ST_LOSE       = 3'd6
    } state_t;

    state_t        state_r;
    logic [6:0]    level_r;
    logic [5:0]    idx_r;
    logic [TW-1:0] timer_r;
    logic [15:0]   lfsr_r;
    logic [1:0]    mem_r [0:63];

    logic [1:0]    expected_r;
    logic          cmp_enable_r;
    logic          led_on_r;
    logic [1:0]    led_colour_r;
    logic          busy_r;
    logic          win_r;
    logic          game_over_r;

    logic [6:0]    lvl_m1_s;
    logic [6:0]    idx_inc_s;
    logic          idx_last_s;
    logic          match_s;
    logic          mismatch_s;
    logic [1:0]    mem_first_s;
    logic [1:0]    mem_next_s;
    logic [TW-1:0] on_load_s;

    // Step bookkeeping and the two sequence-memory read ports.
    always_comb begin
        lvl_m1_s   = level_r - 7'd1;
        idx_inc_s  = {1'b0, idx_r} + 7'd1;
        idx_last_s = ({1'b0, idx_r} == lvl_m1_s);
        match_s    = result_valid && (result == 2'b01);
        mismatch_s = result_valid && (result == 2'b10);
        mem_next_s = mem_r[idx_inc_s[5:0]];
        // In EXTEND of round 1, entry 0 is being written this very edge, so the
        // first colour played must come straight from the LFSR.
        if ((state_r == ST_EXTEND) && (level_r == 7'd1)) begin
            mem_first_s = lfsr_r[1:0];
        end else begin
            mem_first_s = mem_r[6'd0];
        end
    end

    // Lit time for the current level.
    always_comb begin
        on_load_s = ON_LOAD_BASE;
`ifdef SIMON_SPEEDUP_EN
        if (level_r >= 7'd8) begin
            on_load_s = ON_LOAD_L8;
        end else if (level_r >= 7'd4) begin
            on_load_s = ON_LOAD_L4;
        end else begin
            on_load_s = ON_LOAD_BASE;
        end
`endif
    end

    // Free-running colour source, advances every clock in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // Sequence memory: not cleared by reset; EXTEND writes the newest colour.
    always_ff @(posedge clk) begin
        if (state_r == ST_EXTEND) begin
            mem_r[lvl_m1_s[5:0]] <= lfsr_r[1:0];
        end
    end

    // Game FSM; outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            level_r      <= 7'd0;
            idx_r        <= 6'd0;
            timer_r      <= '0;
            expected_r   <= 2'b00;
            cmp_enable_r <= 1'b0;
            led_on_r     <= 1'b0;
            led_colour_r <= 2'b00;
            busy_r       <= 1'b0;
            win_r        <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        // level restarts at 0 and EXTEND's increment is folded
                        // into this edge, so level already reads 1 in EXTEND.
                        state_r     <= ST_EXTEND;
                        level_r     <= 7'd1;
                        idx_r       <= 6'd0;
                        timer_r     <= '0;
                        busy_r      <= 1'b1;
                        win_r       <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                end
                ST_EXTEND: begin
                    state_r      <= ST_PLAY_ON;
                    idx_r        <= 6'd0;
                    timer_r      <= on_load_s;
                    led_on_r     <= 1'b1;
                    led_colour_r <= mem_first_s;
                end
                ST_PLAY_ON: begin
                    if (timer_r == '0) begin
                        state_r      <= ST_PLAY_OFF;
                        timer_r      <= OFF_LOAD;
                        led_on_r     <= 1'b0;
                        led_colour_r <= 2'b00;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                ST_PLAY_OFF: begin
                    if (timer_r != '0) begin
                        timer_r <= timer_r - TW'(1);
                    end else if (idx_inc_s == level_r) begin
                        state_r      <= ST_WAIT_INPUT;
                        idx_r        <= 6'd0;
                        timer_r      <= '0;
                        cmp_enable_r <= 1'b1;
                        expected_r   <= mem_first_s;
                    end else begin
                        state_r      <= ST_PLAY_ON;
                        idx_r        <= idx_inc_s[5:0];
                        timer_r      <= on_load_s;
                        led_on_r     <= 1'b1;
                        led_colour_r <= mem_next_s;
                    end
                end
                ST_WAIT_INPUT: begin
                    if (match_s && !idx_last_s) begin
                        idx_r      <= idx_inc_s[5:0];
                        expected_r <= mem_next_s;
                    end else if (match_s && (level_r == MAX_LEVEL)) begin
                        state_r      <= ST_WIN;
                        cmp_enable_r <= 1'b0;
                        expected_r   <= 2'b00;
                        busy_r       <= 1'b0;
                        win_r        <= 1'b1;
                    end else if (match_s) begin
                        // Increment folded into entry, as from IDLE.
                        state_r      <= ST_EXTEND;
                        level_r      <= level_r + 7'd1;
                        timer_r      <= '0;
                        cmp_enable_r <= 1'b0;
                        expected_r   <= 2'b00;
                    end else if (mismatch_s) begin
                        state_r      <= ST_LOSE;
                        cmp_enable_r <= 1'b0;
                        expected_r   <= 2'b00;
                        busy_r       <= 1'b0;
                        game_over_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    level_r      <= 7'd0;
                    idx_r        <= 6'd0;
                    timer_r      <= '0;
                    expected_r   <= 2'b00;
                    cmp_enable_r <= 1'b0;
                    led_on_r     <= 1'b0;
                    led_colour_r <= 2'b00;
                    busy_r       <= 1'b0;
                    win_r        <= 1'b0;
                    game_over_r  <= 1'b0;
                end
            endcase
        end
    end

    assign expected   = expected_r;
    assign cmp_enable = cmp_enable_r;
    assign led_on     = led_on_r;
    assign led_colour = led_colour_r;
    assign level      = level_r;
    assign busy       = busy_r;
    assign win        = win_r;
    assign game_over  = game_over_r;

endmodule
